lw_hmac_feeder: RTL

LW_HMAC_FEEDER -- requirements
Module: lw_hmac_feeder

---
 rtl/lw_sha_pkg.sv | 21 ++
 rtl/lw_hmac_msg_fifo.sv | 52 +++++
 rtl/lw_hmac_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lw_sha_pkg.sv
// Shared types for the lightweight SHA/HMAC front end: feeder FSM states and
// the opcode bit that selects HMAC.
package lw_sha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYLD,
    ST_START,
    ST_KEY,
    ST_MSG,
    ST_WAIT,
    ST_RESULT
  } feeder_state_e;

  localparam int unsigned HMAC_OP_BIT = 3;

  function automatic logic is_hmac(input logic [3:0] opcode);
    return opcode[HMAC_OP_BIT];
  endfunction

endpackage

// File: rtl/lw_hmac_msg_fifo.sv
// Message FIFO for the HMAC feeder: stores data plus a last tag per entry,
// with push/pop/flush and full/empty flags. A push while full is refused.
module lw_hmac_msg_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_push;
  logic           do_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= {push_last_i, push_data_i};
  end

  assign {head_last_o, head_data_o} = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lw_hmac_feeder.sv
// Sequences key and message words from the host into a SHA/HMAC engine and
// returns the digest. Define FEEDER_KEY_WIPE_EN to zero the key buffer after use.
module lw_hmac_feeder
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_WORDS  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cmd_start_i,
  input  logic [3:0]                cmd_opcode_i,
  input  logic                      abort_i,
  input  logic [WORD_SIZE-1:0]      host_key_i,
  input  logic                      host_key_valid_i,
  output logic                      host_key_ready_o,
  input  logic [WORD_SIZE-1:0]      msg_data_i,
  input  logic                      msg_valid_i,
  input  logic                      msg_last_i,
  output logic                      msg_ready_o,
  output logic                      eng_start_o,
  output logic                      eng_abort_o,
  output logic                      eng_last_o,
  output logic                      eng_data_valid_o,
  output logic                      eng_key_valid_o,
  output logic [3:0]                eng_opcode_o,
  output logic [WORD_SIZE-1:0]      eng_data_o,
  output logic [WORD_SIZE-1:0]      eng_key_o,
  input  logic                      eng_ready_i,
  input  logic                      eng_key_ready_i,
  input  logic                      eng_done_i,
  input  logic [7:0][WORD_SIZE-1:0] eng_hash_i,
  output logic [7:0][WORD_SIZE-1:0] res_hash_o,
  output logic                      res_valid_o,
  input  logic                      res_ack_i,
  output logic                      busy_o
);

  localparam int KIW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [KIW-1:0] KEY_LAST = KIW'(KEY_WORDS - 1);

  feeder_state_e             state_q;
  logic [3:0]                opcode_q;
  logic [KIW-1:0]            key_idx_q;
  logic [WORD_SIZE-1:0]      key_buf [KEY_WORDS];
  logic                      last_pending_q;
  logic                      eng_abort_q;
  logic [7:0][WORD_SIZE-1:0] res_hash_q;

  logic                 abort_req;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 head_last;
  logic [WORD_SIZE-1:0] head_data;
  logic                 msg_pop;
  logic                 key_accept;
  logic                 key_xfer;
  logic                 key_at_last;

  assign abort_req   = abort_i && (state_q != ST_IDLE);
  assign key_accept  = (state_q == ST_KEYLD) && host_key_valid_i;
  assign key_xfer    = (state_q == ST_KEY) && eng_key_ready_i;
  assign key_at_last = (key_idx_q == '0);
  assign msg_pop     = (state_q == ST_MSG) && !fifo_empty && eng_ready_i;
  assign fifo_push   = msg_valid_i && msg_ready_o;

  // Once a last-tagged word is queued, the next message must wait for it to drain.
  assign msg_ready_o = !fifo_full && !last_pending_q && !abort_req;

  lw_hmac_msg_fifo #(
    .WIDTH(WORD_SIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_msg_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (fifo_push),
    .push_data_i(msg_data_i),
    .push_last_i(msg_last_i),
    .pop_i      (msg_pop),
    .flush_i    (abort_req),
    .head_data_o(head_data),
    .head_last_o(head_last),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || abort_req) begin
      last_pending_q <= 1'b0;
    end else if (fifo_push && msg_last_i) begin
      last_pending_q <= 1'b1;
    end else if (msg_pop && head_last) begin
      last_pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      key_idx_q   <= KEY_LAST;
      eng_abort_q <= 1'b0;
      res_hash_q  <= '0;
    end else begin
      eng_abort_q <= abort_req;
      if (abort_req) begin
        state_q   <= ST_IDLE;
        key_idx_q <= KEY_LAST;
      end else begin
        case (state_q)
          ST_IDLE: if (cmd_start_i) begin
            opcode_q <= cmd_opcode_i;
            state_q  <= is_hmac(cmd_opcode_i) ? ST_KEYLD : ST_START;
          end
          ST_KEYLD: if (key_accept) begin
            key_idx_q <= key_at_last ? KEY_LAST : key_idx_q - 1'b1;
            if (key_at_last) state_q <= ST_START;
          end
          ST_START: if (!fifo_empty) begin
            state_q <= is_hmac(opcode_q) ? ST_KEY : ST_MSG;
          end
          ST_KEY: if (key_xfer) begin
            key_idx_q <= key_at_last ? KEY_LAST : key_idx_q - 1'b1;
            if (key_at_last) state_q <= ST_MSG;
          end
          ST_MSG: if (msg_pop && head_last) state_q <= ST_WAIT;
          ST_WAIT: if (eng_done_i) begin
            res_hash_q <= eng_hash_i;
            state_q    <= ST_RESULT;
          end
          ST_RESULT: if (res_ack_i) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FEEDER_KEY_WIPE_EN
  logic key_wipe;
  assign key_wipe = abort_req || (key_xfer && key_at_last);

  always_ff @(posedge clk_i) begin
    if (key_wipe) begin
      for (int i = 0; i < KEY_WORDS; i++) key_buf[i] <= '0;
    end else if (key_accept) begin
      key_buf[key_idx_q] <= host_key_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (key_accept) key_buf[key_idx_q] <= host_key_i;
  end
`endif

  // The start strobe presents the head word alongside eng_start_o but does not consume it.
  assign busy_o           = (state_q != ST_IDLE);
  assign host_key_ready_o = (state_q == ST_KEYLD);
  assign eng_start_o      = (state_q == ST_START) && !fifo_empty;
  assign eng_data_valid_o = ((state_q == ST_START) || (state_q == ST_MSG)) && !fifo_empty;
  assign eng_data_o       = eng_data_valid_o ? head_data : '0;
  assign eng_last_o       = (state_q == ST_MSG) && !fifo_empty && head_last;
  assign eng_key_valid_o  = (state_q == ST_KEY);
  assign eng_key_o        = eng_key_valid_o ? key_buf[key_idx_q] : '0;
  assign eng_opcode_o     = (state_q inside {ST_START, ST_KEY, ST_MSG, ST_WAIT}) ? opcode_q : 4'h0;
  assign eng_abort_o      = eng_abort_q;
  assign res_valid_o      = (state_q == ST_RESULT);
  assign res_hash_o       = res_hash_q;

endmodule
